zuc_stream_xor: RTL
===================

// Module: zuc_stream_xor
// PURPOSE
//  Packet-level initiator for zuc_ctl. Takes 32-bit plaintext/ciphertext words with a per-packet IV and key.
//  Issues the IV/key control beat, then one keystream request per data word. Buffers the data words.
//  XORs each buffered word with the returned keystream word, i.e. the EEA3-style data path.
//  Sits between the packet source and a zuc_ctl instance (uw=1; user carries the last flag).
// PARAMETERS
//  DEPTH   16  data FIFO depth, power of two >= 2; must cover zuc_ctl round-trip latency for 1 word/clk
// PORTS
//  clk           in   1    clock; all logic on posedge
//  resetn        in   1    asynchronous, active-low reset
//  s_valid       in   1    input word valid
//  s_ready       out  1    input word accepted when s_valid && s_ready
//  s_data        in   32   input word; byte 0 of stream = s_data[31:24]
//  s_keep        in   4    byte enables, s_keep[3] <-> s_data[31:24]; must be 4'hF unless s_last
//  s_last        in   1    last word of packet
//  s_iv          in   128  packet IV, sampled only on the first word of a packet
//  s_key         in   128  packet key, sampled only on the first word of a packet
//  ks_ctl_valid  out  1    to zuc_ctl s_ctl_valid
//  ks_ctl_ready  in   1    from zuc_ctl s_ctl_ready
//  ks_ctl_iv     out  128  to zuc_ctl s_ctl_iv
//  ks_ctl_key    out  128  to zuc_ctl s_ctl_key
//  ks_req_valid  out  1    to zuc_ctl s_valid
//  ks_req_ready  in   1    from zuc_ctl s_ready
//  ks_req_last   out  1    to zuc_ctl s_last and s_user[0]
//  ks_valid      in   1    from zuc_ctl m_valid
//  ks_ready      out  1    to zuc_ctl m_ready
//  ks_data       in   32   from zuc_ctl m_cipher (keystream word)
//  ks_user       in   1    from zuc_ctl m_user (echoed last flag)
//  m_valid       out  1    output word valid
//  m_ready       in   1    output word accepted when m_valid && m_ready
//  m_data        out  32   (fifo_data ^ ks_data) with bytes where m_keep=0 forced to 8'h00
//  m_keep        out  4    copy of the input s_keep
//  m_last        out  1    copy of the input s_last
//  err           out  1    sticky: ks_user != FIFO-head last on an output handshake
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, FIFO empty, err=0.
//   Outputs during reset: s_ready, ks_ctl_valid, ks_req_valid, ks_ready and m_valid are all 0.
//  System requirement: zuc_ctl has no reset. The integrator resets or flushes it together with this block.
//  FSM:
//   IDLE: ks_ctl_valid = s_valid. ks_ctl_iv/key = s_iv/s_key, combinational pass-through.
//    The s word is NOT consumed; s_ready=0. On ctl handshake -> DATA.
//   DATA: ks_req_valid = s_valid && !full. ks_req_last = s_last.
//    s_ready = !full && ks_req_ready.
//    On s handshake, in the same cycle: push {s_data, s_keep, s_last} into the FIFO; that edge is the zuc request.
//    On s handshake with s_last -> IDLE.
//  A held IDLE request must keep s_iv/s_key stable until ks_ctl_ready; this is a source-side rule.
//  ks_req_valid never depends on ks_req_ready, and ks_ctl_valid never depends on ks_ctl_ready.
//  Output side is combinational from the FIFO head and the ks port; there is no register stage:
//   m_valid = ks_valid && !empty.
//   ks_ready = m_ready && !empty.
//   Pop on m handshake.
//  A keystream word is never consumed without a FIFO word, and vice versa.
//  Throughput: 1 word/clk in steady state. Each packet costs 1 extra clk (IDLE ctl beat) plus zuc_ctl init time.
//  FIFO: DEPTH entries, occupancy counter of width $clog2(DEPTH)+1.
//   Read/write pointers wrap modulo DEPTH.
//   Simultaneous push and pop when full: push is blocked (full=1 gates s_ready). The pop still happens.
//   Simultaneous push and pop when empty: only the push happens. No fall-through; m_valid rises the next clk.
//  Back-to-back packets: IDLE may issue the next ctl beat while the previous packet's words are still in the FIFO.
//   Ordering is preserved because zuc_ctl serialises.
//  err: set when m handshake and ks_user != head.last. Cleared only by reset. Data still passes.
//  Single-word packet: IDLE(ctl) -> DATA(1 word, last) -> IDLE.
// STRUCTURE
//  zuc_defs.vh: localparams for IDLE/DATA encoding, the FIFO entry width (32+4+1=37), and the keep-mask function.
//  Sub-module zuc_sync_fifo (parameters W, DEPTH; async active-low reset on pointers/count; storage not reset).
//  Top: FSM + handshake glue + XOR/mask.
// TESTING
//  Bench uses a zuc_ctl behavioural stub: ks word n of a packet = 32'hA5A5_0000 + n; latency 3 clk.
//   The stub echoes the last flag as user. Also run once with the real zuc_ctl.
//  1. Reset: hold resetn=0 with s_valid=1 -> all valids/readies 0. Release -> ks_ctl_valid=1 next clk.
//  2. 4-word packet, data 0,1,2,3, keep F, m_ready=1 -> m_data A5A50000..A5A50003, m_last on word 3.
//     ks_ctl handshake exactly once.
//  3. Last word keep=4'hC, data FFFFFFFF, ks A5A50000 -> m_data 5A5A0000, m_keep C.
//  4. m_ready=0 for 40 clk, DEPTH=16 -> exactly 16 words accepted, s_ready=0 after.
//     Release -> all words in order, no loss.
//  5. Two back-to-back 1-word packets with different iv -> two ctl beats; outputs 0^A5A50000 for both; err=0.
//  6. Stub corrupts user on word 2 -> err=1 from that clk on. Assert resetn=0 mid-packet -> FIFO empty, state IDLE.

Source files
------------

// File: rtl/zuc_stream_xor_pkg.sv
// Shared types and helpers for the ZUC stream XOR initiator: FSM encoding,
// buffered-word layout and the byte-keep mask.
package zuc_stream_xor_pkg;

    localparam int DATA_W  = 32;
    localparam int KEEP_W  = 4;
    localparam int ENTRY_W = DATA_W + KEEP_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } entry_t;

    // keep[3] enables the most significant byte, which is byte 0 of the stream
    function automatic logic [DATA_W-1:0] keep_mask(input logic [KEEP_W-1:0] keep);
        logic [DATA_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            mask[i*8 +: 8] = {8{keep[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/zuc_stream_xor_sync_fifo.sv
// Synchronous FIFO with an occupancy counter; pointers and count are reset,
// storage is not. Push is ignored when full, pop is ignored when empty.
module zuc_sync_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap by natural overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/zuc_stream_xor.sv
// Packet-level initiator for zuc_ctl: issues the IV/key beat, one keystream
// request per data word, buffers the words and XORs them with the keystream.
module zuc_stream_xor
    import zuc_stream_xor_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    input  logic [KEEP_W-1:0]   s_keep,
    input  logic                s_last,
    input  logic [127:0]        s_iv,
    input  logic [127:0]        s_key,
    output logic                ks_ctl_valid,
    input  logic                ks_ctl_ready,
    output logic [127:0]        ks_ctl_iv,
    output logic [127:0]        ks_ctl_key,
    output logic                ks_req_valid,
    input  logic                ks_req_ready,
    output logic                ks_req_last,
    input  logic                ks_valid,
    output logic                ks_ready,
    input  logic [DATA_W-1:0]   ks_data,
    input  logic                ks_user,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATA_W-1:0]   m_data,
    output logic [KEEP_W-1:0]   m_keep,
    output logic                m_last,
    output logic                err
);

    state_e               state_q, state_d;
    logic                 run_q;
    logic                 err_q, err_d;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic [ENTRY_W-1:0]   fifo_rdata;
    entry_t               wr_entry;
    entry_t               head;

    assign wr_entry = '{data: s_data, keep: s_keep, last: s_last};
    assign head     = entry_t'(fifo_rdata);

    zuc_sync_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .wdata  (wr_entry),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // run_q gives a synchronous release: every valid/ready stays low until the first clock after reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        ks_ctl_valid = 1'b0;
        ks_req_valid = 1'b0;
        s_ready      = 1'b0;
        push         = 1'b0;
        ks_ctl_iv    = s_iv;
        ks_ctl_key   = s_key;
        ks_req_last  = s_last;
        unique case (state_q)
            ST_IDLE: begin
                ks_ctl_valid = run_q && s_valid;
                if (ks_ctl_valid && ks_ctl_ready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                ks_req_valid = run_q && s_valid && !fifo_full;
                s_ready      = run_q && !fifo_full && ks_req_ready;
                push         = s_valid && s_ready;
                if (push && s_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output path is purely combinational from the FIFO head and the keystream port
    always_comb begin
        m_valid  = run_q && ks_valid && !fifo_empty;
        ks_ready = run_q && m_ready && !fifo_empty;
        pop      = m_valid && m_ready;
        m_data   = (head.data ^ ks_data) & keep_mask(head.keep);
        m_keep   = head.keep;
        m_last   = head.last;
        err_d    = err_q || (pop && (ks_user != head.last));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;

endmodule
